// File: rtl/req_onehot_arbiter.sv
`timescale 1ns/1ps
// req_onehot_arbiter
// Captures rising edges on eight request lines into sticky pending bits and
// hands them out one at a time as a registered one-hot grant plus binary
// index over a valid/ack handshake. Bit 7 has the highest priority.
module req_onehot_arbiter #(
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              En,
  input  logic [7:0]        req,
  input  logic              ack,
  output logic [7:0]        grant,
  output logic [2:0]        idx,
  output logic              valid,
  output logic [7:0]        pending,
  output logic [DROP_W-1:0] drop_cnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Saturation ceiling expressed in the widened sum domain.
  localparam logic [DROP_W+3:0] DROP_MAX = {4'b0000, {DROP_W{1'b1}}};

  state_t            state;
  state_t            state_next;
  logic [7:0]        req_prev;
  logic [7:0]        req_edge;
  logic [7:0]        clr;
  logic [7:0]        pending_next;
  logic [7:0]        dropped;
  logic [3:0]        drop_inc;
  logic [DROP_W+3:0] drop_sum;
  logic [DROP_W-1:0] drop_next;
  logic [2:0]        top_idx;
  logic [7:0]        grant_next;
  logic [2:0]        idx_next;
  logic              valid_next;

  // Edge detection, pending set/clear (set wins) and saturating drop count.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    req_edge     = req & ~req_prev;
    clr          = (state == GRANT && ack) ? grant : 8'h00;
    pending_next = (pending & ~clr) | req_edge;
    dropped      = req_edge & pending & ~clr;
    drop_inc     = 4'd0;
    for (int i = 0; i < 8; i++) begin
      if (dropped[i]) drop_inc = drop_inc + 4'd1;
    end
    drop_sum  = {4'b0000, drop_cnt} + {{DROP_W{1'b0}}, drop_inc};
    drop_next = (drop_sum > DROP_MAX) ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
  end

  // Fixed-priority encoder: later (higher) bits overwrite lower ones.
  always_comb begin
    top_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (pending[i]) top_idx = 3'(i);
    end
  end

  // FSM next state and next registered outputs; hold is the default.
  always_comb begin
    state_next = state;
    grant_next = grant;
    idx_next   = idx;
    valid_next = valid;
    case (state)
      IDLE: begin
        if (En && pending != 8'h00) begin
          state_next = GRANT;
          grant_next = 8'(1) << top_idx;
          idx_next   = top_idx;
          valid_next = 1'b1;
        end
      end
      GRANT: begin
        if (ack) begin
          state_next = IDLE;
          grant_next = 8'h00;
          idx_next   = 3'd0;
          valid_next = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = 8'h00;
        idx_next   = 3'd0;
        valid_next = 1'b0;
      end
    endcase
  end

  // State, capture and output registers; reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      req_prev <= 8'h00;
      pending  <= 8'h00;
      drop_cnt <= '0;
      grant    <= 8'h00;
      idx      <= 3'd0;
      valid    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed above, independent of statement order.
      state    <= state_next;
      req_prev <= req;
      pending  <= pending_next;
      drop_cnt <= drop_next;
      grant    <= grant_next;
      idx      <= idx_next;
      valid    <= valid_next;
    end
  end

endmodule

// File: tb/tb_req_onehot_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for req_onehot_arbiter: directed stimulus pushes the
// expected grant index into a queue; a monitor pops it when valid rises.
module tb_req_onehot_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       En;
  logic [7:0] req;
  logic       ack;
  logic [7:0] grant;
  logic [2:0] idx;
  logic       valid;
  logic [7:0] pending;
  logic [7:0] drop_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [2:0] exp_q[$];
  logic       valid_seen = 1'b0;

  req_onehot_arbiter #(.DROP_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .En       (En),
    .req      (req),
    .ack      (ack),
    .grant    (grant),
    .idx      (idx),
    .valid    (valid),
    .pending  (pending),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every new grant must match the next queued index.
  always @(negedge clk) begin
    if (rst) begin
      valid_seen <= 1'b0;
    end else begin
      if (valid && !valid_seen) begin
        if (exp_q.size() == 0) begin
          check("unexpected_grant_idx", {29'd0, idx}, 32'hFFFF_FFFF);
        end else begin
          logic [2:0] e;
          e = exp_q.pop_front();
          check("sb_idx", {29'd0, idx}, {29'd0, e});
          check("sb_grant", {24'd0, grant}, 32'd1 << e);
        end
      end
      valid_seen <= valid;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; En = 1'b0; req = 8'h00; ack = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_grant",   {24'd0, grant},    32'h0);
    check("rst_idx",     {29'd0, idx},      32'h0);
    check("rst_valid",   {31'd0, valid},    32'h0);
    check("rst_pending", {24'd0, pending},  32'h0);
    check("rst_drop",    {24'd0, drop_cnt}, 32'h0);

    // Single request on bit 5: two-cycle latency, one-cycle ack.
    En = 1'b1;
    exp_q.push_back(3'd5);
    req = 8'h20;
    tick();
    check("single_pending", {24'd0, pending}, 32'h20);
    check("single_valid_lat1", {31'd0, valid}, 32'h0);
    tick();
    check("single_valid", {31'd0, valid}, 32'h1);
    check("single_grant", {24'd0, grant}, 32'h20);
    check("single_idx",   {29'd0, idx},   32'd5);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("single_ack_valid",   {31'd0, valid},   32'h0);
    check("single_ack_pending", {24'd0, pending}, 32'h0);
    req = 8'h00;
    tick();

    // Priority: bits 7 and 0 rise together, 7 first, then 0 after one idle cycle.
    exp_q.push_back(3'd7);
    exp_q.push_back(3'd0);
    req = 8'h81;
    tick();
    tick();
    check("prio_first_grant", {24'd0, grant}, 32'h80);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("prio_idle_valid",  {31'd0, valid},   32'h0);
    check("prio_idle_pend",   {24'd0, pending}, 32'h01);
    tick();
    check("prio_second_grant", {24'd0, grant}, 32'h01);
    check("prio_second_idx",   {29'd0, idx},   32'd0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("prio_done_pend", {24'd0, pending}, 32'h0);
    req = 8'h00;
    tick();

    // Enable gating: capture continues, no grant until En rises.
    En = 1'b0;
    req = 8'h10;
    tick();
    req = 8'h00;
    check("gate_pending", {24'd0, pending}, 32'h10);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("gate_valid_low", {31'd0, valid}, 32'h0);
    end
    exp_q.push_back(3'd4);
    En = 1'b1;
    tick();
    check("gate_valid", {31'd0, valid}, 32'h1);
    check("gate_idx",   {29'd0, idx},   32'd4);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("gate_pend_clear", {24'd0, pending}, 32'h0);

    // Drop: second pulse on a pending, ungranted bit.
    En = 1'b0;
    req = 8'h04; tick();
    req = 8'h00; tick();
    req = 8'h04; tick();
    req = 8'h00; tick();
    check("drop_one",      {24'd0, drop_cnt}, 32'd1);
    check("drop_pend",     {24'd0, pending},  32'h04);

    // Set wins: pulse bit 2 in its ack cycle.
    exp_q.push_back(3'd2);
    En = 1'b1;
    tick();
    check("setwin_grant", {24'd0, grant}, 32'h04);
    exp_q.push_back(3'd2);
    req = 8'h04;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("setwin_pend",  {24'd0, pending},  32'h04);
    check("setwin_drop",  {24'd0, drop_cnt}, 32'd1);
    check("setwin_valid", {31'd0, valid},    32'h0);
    tick();
    check("setwin_regrant", {24'd0, grant}, 32'h04);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    req = 8'h00;
    check("setwin_clear", {24'd0, pending}, 32'h0);

    // Saturation: 300 further drops on bit 2.
    En = 1'b0;
    req = 8'h04; tick();
    req = 8'h00; tick();
    for (int i = 0; i < 300; i++) begin
      req = 8'h04; tick();
      req = 8'h00; tick();
    end
    check("drop_sat", {24'd0, drop_cnt}, 32'd255);
    exp_q.push_back(3'd2);
    En = 1'b1;
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("sat_clear", {24'd0, pending}, 32'h0);

    // Grant stability: bit 6 and En toggling during a grant on bit 1.
    exp_q.push_back(3'd1);
    req = 8'h02;
    tick();
    tick();
    check("stab_grant0", {24'd0, grant}, 32'h02);
    req = 8'h42; En = 1'b0;
    tick();
    check("stab_grant1", {24'd0, grant}, 32'h02);
    check("stab_idx1",   {29'd0, idx},   32'd1);
    check("stab_pend1",  {24'd0, pending}, 32'h42);
    En = 1'b1;
    tick();
    check("stab_grant2", {24'd0, grant}, 32'h02);
    En = 1'b0;
    tick();
    check("stab_idx3",   {29'd0, idx},   32'd1);
    check("stab_valid3", {31'd0, valid}, 32'h1);
    En = 1'b1;
    exp_q.push_back(3'd6);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("stab_after_ack_pend", {24'd0, pending}, 32'h40);
    tick();
    check("stab_next_idx", {29'd0, idx}, 32'd6);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    req = 8'h00;
    tick();

    // Asynchronous reset mid-grant with all lines pending.
    exp_q.push_back(3'd7);
    req = 8'hFF;
    tick();
    tick();
    check("prerst_valid", {31'd0, valid}, 32'h1);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("arst_grant",   {24'd0, grant},    32'h0);
    check("arst_idx",     {29'd0, idx},      32'h0);
    check("arst_valid",   {31'd0, valid},    32'h0);
    check("arst_pending", {24'd0, pending},  32'h0);
    check("arst_drop",    {24'd0, drop_cnt}, 32'h0);
    req = 8'h00;
    tick();
    rst = 1'b0;
    tick();
    tick();
    check("post_rst_valid",   {31'd0, valid},   32'h0);
    check("post_rst_pending", {24'd0, pending}, 32'h0);
    check("post_rst_grant",   {24'd0, grant},   32'h0);

    check("sb_queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
